range_session_ctrl: RTL

Session controller for the min/max range tracker in the measurement chip. It takes `go`/`finish` commands and streams 10-bit samples, owning the min/max registers for each session. It delivers the final range/max/min over a valid/ready result port, and detects protocol errors and over-long sessions with a sticky error code. It sits between the pad-level command inputs and the output mux that drives `io_out`.

---
 rtl/range_session_ctrl_if.sv | 29 ++
 rtl/range_session_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/range_session_ctrl_if.sv
// rtl/range_session_ctrl_if.sv - command, sample and result signals of range_session_ctrl
interface range_session_ctrl_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
);
  logic              go;
  logic              finish;
  logic [DATA_W-1:0] data_in;
  logic              err_clr;
  logic              res_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_range;
  logic [DATA_W-1:0] res_max;
  logic [DATA_W-1:0] res_min;
  logic [CNT_W-1:0]  res_count;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output go, finish, data_in, err_clr, res_ready,
    input  res_valid, res_range, res_max, res_min, res_count, busy, err, err_code
  );

  modport slave (
    input  go, finish, data_in, err_clr, res_ready,
    output res_valid, res_range, res_max, res_min, res_count, busy, err, err_code
  );
endinterface

// File: rtl/range_session_ctrl.sv
// rtl/range_session_ctrl.sv - min/max range session controller with sticky error code
// Optional macro RANGE_CTRL_STATS_EN reports the session sample count on res_count.
module range_session_ctrl #(
  parameter int DATA_W      = 10,
  parameter int CNT_W       = 8,
  parameter int MAX_SAMPLES = 200
) (
  input logic                 clock,
  input logic                 reset,
  range_session_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_SAMPLES - 1);

  state_t            state, state_nx;
  logic [1:0]        code_q, code_nx;
  logic              start, capture;
  logic [DATA_W-1:0] cur_min, cur_max, upd_min, upd_max;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] res_range_q, res_max_q, res_min_q;

  always_comb begin
    upd_min = (bus.data_in < cur_min) ? bus.data_in : cur_min;
    upd_max = (bus.data_in > cur_max) ? bus.data_in : cur_max;
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    start    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.go && bus.finish) begin
          state_nx = ERR;
          code_nx  = 2'b10;
        end else if (bus.finish) begin
          state_nx = ERR;
          code_nx  = 2'b01;
        end else if (bus.go) begin
          start    = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.go) begin
          state_nx = ERR;
          code_nx  = 2'b10;
        end else if (bus.finish) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else if (cnt == LAST_CNT) begin
          // this cycle's sample is number MAX_SAMPLES and no finish came with it
          state_nx = ERR;
          code_nx  = 2'b11;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          if (bus.go) begin
            start    = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      ERR: begin
        if (bus.err_clr) begin
          state_nx = IDLE;
          code_nx  = 2'b00;
        end
      end
      default: begin
        state_nx = IDLE;
        code_nx  = 2'b00;
      end
    endcase
    // a one-sample limit means the opening sample already exhausts the session
    if (start && (MAX_SAMPLES == 1)) begin
      state_nx = ERR;
      code_nx  = 2'b11;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      code_q <= 2'b00;
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_min     <= '1;
      cur_max     <= '0;
      cnt         <= '0;
      res_range_q <= '0;
      res_max_q   <= '0;
      res_min_q   <= '1;
    end else begin
      if (start) begin
        cur_min <= bus.data_in;
        cur_max <= bus.data_in;
        cnt     <= ONE;
      end else if (state == RUN) begin
        cur_min <= upd_min;
        cur_max <= upd_max;
        cnt     <= cnt + ONE;
      end
      if (capture) begin
        res_max_q   <= upd_max;
        res_min_q   <= upd_min;
        res_range_q <= upd_max - upd_min;
      end
    end
  end

`ifdef RANGE_CTRL_STATS_EN
  logic [CNT_W-1:0] res_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      res_count_q <= '0;
    end else if (capture) begin
      res_count_q <= cnt + ONE;
    end
  end

  assign bus.res_count = res_count_q;
`else
  assign bus.res_count = '0;
`endif

  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.err       = (state == ERR);
  assign bus.err_code  = code_q;
  assign bus.res_range = res_range_q;
  assign bus.res_max   = res_max_q;
  assign bus.res_min   = res_min_q;
endmodule
